// File: rtl/pulse_period_meter.sv
// pulse_period_meter: measures rising-edge-to-rising-edge interval of `in` in clk cycles.
// Optional lock detection compiled in with `define PULSE_PERIOD_METER_LOCK_EN.
module pulse_period_meter #(
    parameter int N          = 8,
    parameter int LOCK_COUNT = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         in,
    output logic [N-1:0] period,
    output logic         valid,
    output logic         overflow,
    output logic         locked
);

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        TIMEOUT
    } state_t;

    localparam logic [N-1:0] CNT_MAX = '1;
    localparam logic [N-1:0] CNT_ONE = N'(1);

    state_t       state_q, state_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic [N-1:0] period_q, period_d;
    logic         in_d_q;
    logic         valid_q, valid_d;
    logic         ovf_q, ovf_d;
    logic         rise;
    logic         upd;
    logic         to_tmo;

    assign rise = ena & in & ~in_d_q;

    // Next-state: edge handling, interval counting and saturation
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;
        upd      = 1'b0;
        to_tmo   = 1'b0;
        if (ena) begin
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (rise) begin
                        state_d = MEASURE;
                        cnt_d   = CNT_ONE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_d = cnt_q;
                        valid_d  = 1'b1;
                        upd      = 1'b1;
                        cnt_d    = CNT_ONE;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = TIMEOUT;
                        ovf_d   = 1'b1;
                        to_tmo  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                TIMEOUT: begin
                    if (rise) begin
                        state_d = MEASURE;
                        cnt_d   = CNT_ONE;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            in_d_q   <= 1'b0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            if (ena) begin
                in_d_q <= in;
            end
        end
    end

    assign period   = period_q;
    assign valid    = valid_q;
    assign overflow = ovf_q;

`ifdef PULSE_PERIOD_METER_LOCK_EN
    localparam logic [3:0] MATCH_MAX = 4'(LOCK_COUNT - 1);

    logic [3:0] match_q, match_d;
    logic       ref_q, ref_d;
    logic       lock_q, lock_d;

    // Match tracking: first period after IDLE/TIMEOUT is only a reference
    always_comb begin
        match_d = match_q;
        ref_d   = ref_q;
        lock_d  = lock_q;
        if (to_tmo) begin
            match_d = '0;
            ref_d   = 1'b0;
            lock_d  = 1'b0;
        end else if (upd) begin
            if (ref_q && (cnt_q == period_q)) begin
                if (match_q != MATCH_MAX) begin
                    match_d = match_q + 4'd1;
                end
            end else begin
                match_d = '0;
            end
            ref_d  = 1'b1;
            lock_d = (match_d == MATCH_MAX);
        end
    end

    // Lock registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q <= '0;
            ref_q   <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            match_q <= match_d;
            ref_q   <= ref_d;
            lock_q  <= lock_d;
        end
    end

    assign locked = lock_q;
`else
    assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_period_meter.sv
// tb_pulse_period_meter: directed vectors for pulse_period_meter (N=8, LOCK_COUNT=3).
// Lock expectations apply only when PULSE_PERIOD_METER_LOCK_EN is defined.
module tb_pulse_period_meter;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       in_s;
    logic [7:0] period;
    logic       valid;
    logic       overflow;
    logic       locked;

    int total = 0;
    int bad   = 0;

    pulse_period_meter #(
        .N          (8),
        .LOCK_COUNT (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .in       (in_s),
        .period   (period),
        .valid    (valid),
        .overflow (overflow),
        .locked   (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic exp_lock(input logic el);
`ifdef PULSE_PERIOD_METER_LOCK_EN
        return el;
`else
        return 1'b0 & el;
`endif
    endfunction

    // drive in for one cycle; outputs are observed 1 time unit after the edge
    task automatic tick(input logic v);
        in_s = v;
        @(posedge clk);
        #1;
    endtask

    // edge now, then gap-1 low cycles
    task automatic pulse(input string tag, input int gap, input logic ev,
                         input int ep, input logic el);
        tick(1'b1);
        check({tag, "_valid"}, 32'(valid), 32'(ev));
        if (ev) check({tag, "_period"}, 32'(period), 32'(ep));
        check({tag, "_locked"}, 32'(locked), 32'(exp_lock(el)));
        for (int i = 1; i < gap; i++) begin
            tick(1'b0);
            if (i == 1) check({tag, "_vdrop"}, 32'(valid), 32'd0);
        end
    endtask

    initial begin
        logic seen;
        rst  = 1'b1;
        ena  = 1'b1;
        in_s = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_period", 32'(period), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);

        // steady period 5, lock forms on third equal period
        pulse("p5_first", 5, 1'b0, 0, 1'b0);
        pulse("p5_a", 5, 1'b1, 5, 1'b0);
        pulse("p5_b", 5, 1'b1, 5, 1'b0);
        pulse("p5_c", 5, 1'b1, 5, 1'b1);
        pulse("p5_d", 7, 1'b1, 5, 1'b1);
        pulse("p7", 5, 1'b1, 7, 1'b0);

        // timeout after 255 idle counts
        tick(1'b1);
        check("to_edge_valid", 32'(valid), 32'd1);
        check("to_edge_period", 32'(period), 32'd5);
        seen = 1'b0;
        for (int k = 1; k <= 260; k++) begin
            tick(1'b0);
            seen |= valid;
            if (k == 254) check("to_before", 32'(overflow), 32'd0);
            if (k == 255) begin
                check("to_ovf", 32'(overflow), 32'd1);
                check("to_period", 32'(period), 32'd5);
                check("to_locked", 32'(locked), 32'd0);
            end
        end
        check("to_novalid", 32'(seen), 32'd0);
        check("to_ovf_hold", 32'(overflow), 32'd1);
        pulse("to_exit", 4, 1'b0, 0, 1'b0);
        check("to_exit_ovf", 32'(overflow), 32'd0);

        // boundary: edges exactly 255 apart
        pulse("p4", 255, 1'b1, 4, 1'b0);
        check("b255_pre_ovf", 32'(overflow), 32'd0);
        pulse("b255", 6, 1'b1, 255, 1'b0);
        check("b255_ovf", 32'(overflow), 32'd0);

        // enable gating
        tick(1'b1);
        check("g_ref_valid", 32'(valid), 32'd1);
        check("g_ref_period", 32'(period), 32'd6);
        tick(1'b0);
        tick(1'b0);
        ena  = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            tick(1'b0);
            seen |= valid;
        end
        ena = 1'b1;
        repeat (3) tick(1'b0);
        tick(1'b1);
        check("g1_valid", 32'(valid), 32'd1);
        check("g1_period", 32'(period), 32'd6);
        check("g1_locked", 32'(locked), 32'(exp_lock(1'b0)));
        repeat (5) tick(1'b0);
        ena = 1'b0;
        repeat (3) begin
            tick(1'b1);
            seen |= valid;
        end
        check("g_novalid", 32'(seen), 32'd0);
        ena = 1'b1;
        tick(1'b1);
        check("g2_valid", 32'(valid), 32'd1);
        check("g2_period", 32'(period), 32'd6);
        check("g2_locked", 32'(locked), 32'(exp_lock(1'b1)));
        tick(1'b1);
        check("hold_hi_v0", 32'(valid), 32'd0);
        tick(1'b1);
        check("hold_hi_v1", 32'(valid), 32'd0);
        repeat (3) tick(1'b0);

        // asynchronous reset between clock edges
        #2 rst = 1'b1;
        #1;
        check("ar_period", 32'(period), 32'd0);
        check("ar_valid", 32'(valid), 32'd0);
        check("ar_ovf", 32'(overflow), 32'd0);
        check("ar_locked", 32'(locked), 32'd0);
        #1 rst = 1'b0;
        pulse("ar_first", 3, 1'b0, 0, 1'b0);
        pulse("ar_second", 3, 1'b1, 3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
